// File: rtl/riscv_if_fetch_queue_if.sv
// Fetch-queue port bundle: core-side parcel/next-PC signals plus the instruction memory read bus.
// master = fetch queue, slave = core and memory environment.
interface riscv_if_fetch_queue_if #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32
);
    logic [XLEN-1:0]          if_nxt_pc;
    logic                     if_stall_nxt_pc;
    logic                     if_stall;
    logic                     if_flush;
    logic [PARCEL_SIZE-1:0]   if_parcel;
    logic [XLEN-1:0]          if_parcel_pc;
    logic [PARCEL_SIZE/16-1:0] if_parcel_valid;
    logic                     if_parcel_misaligned;
    logic                     if_parcel_page_fault;
    logic                     mem_req;
    logic [XLEN-1:0]          mem_adr;
    logic                     mem_ack;
    logic [PARCEL_SIZE-1:0]   mem_q;
    logic                     mem_err;

    modport master (
        input  if_nxt_pc, if_stall, if_flush, mem_ack, mem_q, mem_err,
        output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault, mem_req, mem_adr
    );

    modport slave (
        output if_nxt_pc, if_stall, if_flush, mem_ack, mem_q, mem_err,
        input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
               if_parcel_misaligned, if_parcel_page_fault, mem_req, mem_adr
    );
endinterface

// File: rtl/riscv_if_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory reads feeding a small parcel FIFO.
//   state   | meaning
//   IDLE    | ready to accept if_nxt_pc when the FIFO has room
//   REQ     | read outstanding, mem_req/mem_adr held until mem_ack
//   DISCARD | read outstanding after a flush, response is dropped
module riscv_if_fetch_queue #(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4
) (
    input logic                     clk,
    input logic                     rstn,
    riscv_if_fetch_queue_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VW    = PARCEL_SIZE / 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_adr_q, mem_adr_d;

    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [PARCEL_SIZE-1:0] store_parcel [DEPTH];
    logic [XLEN-1:0]        store_pc     [DEPTH];
    logic                   store_mis    [DEPTH];
    logic                   store_pf     [DEPTH];

    logic                   stall_nxt_pc, accept, pc_aligned, head_valid, pop, push;
    logic [PARCEL_SIZE-1:0] push_parcel;
    logic [XLEN-1:0]        push_pc;
    logic                   push_mis, push_pf;
    logic [PTR_W-1:0]       push_idx;

    // Back-pressure depends on registered state only.
    assign stall_nxt_pc = (state_q != IDLE) || (count == CNT_W'(DEPTH));
    assign accept       = !stall_nxt_pc;
    assign pc_aligned   = (bus.if_nxt_pc[1:0] == 2'b00);
    assign head_valid   = (count != '0);
    assign pop          = head_valid && !bus.if_stall;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_adr_d   = mem_adr_q;
        push        = 1'b0;
        push_parcel = '0;
        push_pc     = '0;
        push_mis    = 1'b0;
        push_pf     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (pc_aligned) begin
                        state_d   = REQ;
                        mem_req_d = 1'b1;
                        mem_adr_d = bus.if_nxt_pc;
                    end else begin
                        // Misaligned fetches complete locally, even in a flush cycle.
                        push     = 1'b1;
                        push_pc  = bus.if_nxt_pc;
                        push_mis = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    push        = !bus.if_flush;
                    push_parcel = bus.mem_q;
                    push_pc     = mem_adr_q;
                    push_pf     = bus.mem_err;
                end else if (bus.if_flush) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_adr_q <= mem_adr_d;
        end
    end

    // A flush restarts the FIFO at slot 0; a surviving push lands there.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.if_flush) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_W'(1) : '0;
            count  <= push ? CNT_W'(1) : '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (!push && pop) count <= count - CNT_W'(1);
        end
    end

    assign push_idx = bus.if_flush ? '0 : wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            store_parcel[push_idx] <= push_parcel;
            store_pc[push_idx]     <= push_pc;
            store_mis[push_idx]    <= push_mis;
            store_pf[push_idx]     <= push_pf;
        end
    end

    assign bus.if_stall_nxt_pc      = stall_nxt_pc;
    assign bus.mem_req              = mem_req_q;
    assign bus.mem_adr              = mem_adr_q;
    assign bus.if_parcel_valid      = {VW{head_valid}};
    assign bus.if_parcel            = head_valid ? store_parcel[rd_ptr] : '0;
    assign bus.if_parcel_pc         = head_valid ? store_pc[rd_ptr]     : '0;
    assign bus.if_parcel_misaligned = head_valid && store_mis[rd_ptr];
    assign bus.if_parcel_page_fault = head_valid && store_pf[rd_ptr];
endmodule

// File: tb/tb_riscv_if_fetch_queue.sv
// Bench for riscv_if_fetch_queue: queue-based reference model checked every cycle plus directed literal checks.
module tb_riscv_if_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] nxt_pc = 32'h200;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        m_ack = 1'b0;
    logic [31:0] m_q = '0;
    logic        m_err = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    riscv_if_fetch_queue_if #(.XLEN(32), .PARCEL_SIZE(32)) bus ();

    assign bus.if_nxt_pc = nxt_pc;
    assign bus.if_stall  = stall;
    assign bus.if_flush  = flush;
    assign bus.mem_ack   = m_ack;
    assign bus.mem_q     = m_q;
    assign bus.mem_err   = m_err;

    riscv_if_fetch_queue #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a == 32'h200) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: acks after mem_wait request cycles (0 = same cycle), errors on 'h500.
    int mem_wait = 0;
    int wait_cfg = 0;
    int mem_cyc = 0;
    always @(posedge clk) begin
        wait_cfg <= mem_wait;
        if (!rstn || bus.mem_req !== 1'b1 || m_ack) mem_cyc <= 0;
        else mem_cyc <= mem_cyc + 1;
    end
    always @(negedge clk) begin
        m_ack = (bus.mem_req === 1'b1) && (mem_cyc >= wait_cfg);
        m_q   = m_ack ? data_of(bus.mem_adr) : 32'h0;
        m_err = m_ack && (bus.mem_adr == 32'h500);
    end

    // Reference model: list of buffered entries plus an outstanding-read flag.
    typedef struct {
        logic [31:0] parcel;
        logic [31:0] pc;
        logic        mis;
        logic        pf;
    } ent_t;
    ent_t        mq[$];
    logic        m_busy = 1'b0;
    logic        m_disc = 1'b0;
    logic [31:0] m_adr = '0;
    logic        m_acc = 1'b0;
    logic        started = 1'b0;
    logic        saw300 = 1'b0;

    always @(posedge clk) begin
        ent_t e;
        logic got;
        if (!rstn) begin
            mq.delete();
            m_busy  = 1'b0;
            m_disc  = 1'b0;
            m_adr   = '0;
            m_acc   = 1'b0;
            started = 1'b1;
        end else begin
            m_acc = !m_busy && (mq.size() < DEPTH);
            got   = m_busy && m_ack;
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && !stall) void'(mq.pop_front());
                if (got && !m_disc) begin
                    e.parcel = m_q; e.pc = m_adr; e.mis = 1'b0; e.pf = m_err;
                    mq.push_back(e);
                end
            end
            if (got) begin
                m_busy = 1'b0;
                m_disc = 1'b0;
            end else if (flush && m_busy) begin
                m_disc = 1'b1;
            end
            if (m_acc) begin
                if (nxt_pc[1:0] == 2'b00) begin
                    m_busy = 1'b1;
                    m_adr  = nxt_pc;
                end else begin
                    e.parcel = 32'h0; e.pc = nxt_pc; e.mis = 1'b1; e.pf = 1'b0;
                    mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stall_nxt_pc", bus.if_stall_nxt_pc, (m_busy || mq.size() == DEPTH));
            chk("mem_req", bus.mem_req, m_busy);
            chk("mem_adr", bus.mem_adr, m_adr);
            if (mq.size() > 0) begin
                chk("valid", bus.if_parcel_valid, 32'h3);
                chk("parcel", bus.if_parcel, mq[0].parcel);
                chk("parcel_pc", bus.if_parcel_pc, mq[0].pc);
                chk("misaligned", bus.if_parcel_misaligned, mq[0].mis);
                chk("page_fault", bus.if_parcel_page_fault, mq[0].pf);
            end else begin
                chk("valid_empty", bus.if_parcel_valid, 32'h0);
                chk("parcel_empty", bus.if_parcel, 32'h0);
                chk("parcel_pc_empty", bus.if_parcel_pc, 32'h0);
                chk("flags_empty", {bus.if_parcel_misaligned, bus.if_parcel_page_fault}, 32'h0);
            end
            if (bus.if_parcel_valid != 2'b00 && bus.if_parcel_pc == 32'h300) saw300 = 1'b1;
        end
    end

    // Core behaviour: advance to pc+4 after each accepted fetch.
    task automatic tick();
        @(negedge clk);
        if (m_acc) nxt_pc = nxt_pc + 32'd4;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && bus.if_stall_nxt_pc !== 1'b0; i++) tick();
        chk(name, bus.if_stall_nxt_pc, 32'h0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_stall_nxt_pc", bus.if_stall_nxt_pc, 32'h0);
        chk("rst_mem_req", bus.mem_req, 32'h0);
        chk("rst_valid", bus.if_parcel_valid, 32'h0);

        // Zero-wait fetch of 'h200
        rstn = 1'b1;
        tick();
        chk("t1_mem_req", bus.mem_req, 32'h1);
        chk("t1_mem_adr", bus.mem_adr, 32'h200);
        tick();
        chk("t1_valid", bus.if_parcel_valid, 32'h3);
        chk("t1_parcel", bus.if_parcel, 32'h13);
        chk("t1_pc", bus.if_parcel_pc, 32'h200);

        // Fill the FIFO while the core stalls
        flush = 1'b1; stall = 1'b1; nxt_pc = 32'h200;
        tick();
        flush = 1'b0;
        repeat (7) tick();
        chk("fill_count", dut.count, 32'd4);
        chk("fill_stall_nxt_pc", bus.if_stall_nxt_pc, 32'h1);
        chk("fill_head_pc", bus.if_parcel_pc, 32'h200);
        repeat (2) tick();
        chk("full_hold", bus.if_stall_nxt_pc, 32'h1);
        chk("full_no_req", bus.mem_req, 32'h0);
        stall = 1'b0;
        tick();
        chk("drain_head_pc", bus.if_parcel_pc, 32'h204);
        tick();
        chk("drain_req", bus.mem_req, 32'h1);
        chk("drain_adr", bus.mem_adr, 32'h210);

        // Flush during a 3-wait-state read of 'h300
        mem_wait = 3;
        wait_idle("t3_idle");
        nxt_pc = 32'h300;
        tick();
        chk("t3_adr", bus.mem_adr, 32'h300);
        tick();
        flush = 1'b1; nxt_pc = 32'h400;
        tick();
        flush = 1'b0;
        chk("t3_valid", bus.if_parcel_valid, 32'h0);
        chk("t3_state", dut.state_q, 32'd2);
        chk("t3_req_held", bus.mem_req, 32'h1);
        for (int i = 0; i < 40 && bus.if_parcel_valid !== 2'b11; i++) tick();
        chk("t3_head_pc", bus.if_parcel_pc, 32'h400);

        // Memory error on 'h500
        mem_wait = 0;
        wait_idle("t4_idle");
        flush = 1'b1; nxt_pc = 32'h500;
        tick();
        flush = 1'b0; stall = 1'b1;
        chk("t4_adr", bus.mem_adr, 32'h500);
        tick();
        chk("t4_pc", bus.if_parcel_pc, 32'h500);
        chk("t4_page_fault", bus.if_parcel_page_fault, 32'h1);
        chk("t4_valid", bus.if_parcel_valid, 32'h3);
        chk("t4_parcel", bus.if_parcel, 32'hA5A5_0500);

        // Misaligned PC accepted in a flush cycle
        wait_idle("t5_idle");
        flush = 1'b1; nxt_pc = 32'h202;
        tick();
        flush = 1'b0;
        chk("t5_pc", bus.if_parcel_pc, 32'h202);
        chk("t5_misaligned", bus.if_parcel_misaligned, 32'h1);
        chk("t5_parcel", bus.if_parcel, 32'h0);
        chk("t5_no_req", bus.mem_req, 32'h0);
        nxt_pc = 32'h600; mem_wait = 3;

        // Reset mid-request with two entries buffered
        for (int i = 0; i < 40 && !(dut.count == 3'd2 && bus.mem_req === 1'b1); i++) tick();
        chk("t6_setup_count", dut.count, 32'd2);
        rstn = 1'b0;
        tick();
        chk("t6_stall_nxt_pc", bus.if_stall_nxt_pc, 32'h0);
        chk("t6_mem_req", bus.mem_req, 32'h0);
        chk("t6_mem_adr", bus.mem_adr, 32'h0);
        chk("t6_valid", bus.if_parcel_valid, 32'h0);
        chk("t6_parcel", bus.if_parcel, 32'h0);
        chk("t6_pc", bus.if_parcel_pc, 32'h0);
        chk("t6_flags", {bus.if_parcel_misaligned, bus.if_parcel_page_fault}, 32'h0);
        rstn = 1'b1; mem_wait = 0; stall = 1'b0; nxt_pc = 32'h700;
        tick();
        chk("t6_adr", bus.mem_adr, 32'h700);
        chk("t6_req", bus.mem_req, 32'h1);
        tick();
        chk("t6_head_pc", bus.if_parcel_pc, 32'h700);
        chk("t6_head_parcel", bus.if_parcel, 32'hA5A5_0700);

        repeat (10) tick();
        chk("no_h300_presented", saw300, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_if_fetch_queue.md
# riscv_if_fetch_queue

Instruction-fetch front end that sits directly upstream of `riscv_core`'s instruction memory access bus. It takes the next-PC requests the core drives on `if_nxt_pc` and turns them into single-outstanding memory reads. Returned parcels are buffered in a small FIFO and presented to the core on the `if_parcel*` interface. It honours the core's `if_stall` and `if_flush` and back-pressures the core through `if_stall_nxt_pc`.

## Interface
- `XLEN`, 32, address/PC width
- `PARCEL_SIZE`, 32, parcel width; only 32 supported (no RVC)
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  clock
- `rstn`  in  1  synchronous active-low reset; the only clock is `clk`
- `if_nxt_pc`  in  XLEN  next fetch address from core
- `if_stall_nxt_pc`  out  1  core must hold `if_nxt_pc`; high = not accepted
- `if_stall`  in  1  core not consuming head parcel this cycle
- `if_flush`  in  1  discard all buffered and in-flight parcels
- `if_parcel`  out  PARCEL_SIZE  head parcel data
- `if_parcel_pc`  out  XLEN  head parcel address
- `if_parcel_valid`  out  PARCEL_SIZE/16  per-16-bit valid; all ones or all zeros
- `if_parcel_misaligned`  out  1  head entry fetch address not word aligned
- `if_parcel_page_fault`  out  1  head entry memory returned error
- `mem_req`  out  1  read request
- `mem_adr`  out  XLEN  read address
- `mem_ack`  in  1  read complete, `mem_q`/`mem_err` valid this cycle
- `mem_q`  in  PARCEL_SIZE  read data
- `mem_err`  in  1  read error

## Operation
- FSM states: IDLE, REQ, DISCARD. Reset → IDLE.
- `if_stall_nxt_pc` = (state≠IDLE) | (count==DEPTH). It is decoded from registered state only, with no combinational path from any input.
- Accept: if_nxt_pc is accepted in an IDLE cycle with `if_stall_nxt_pc`=0. This applies in flush cycles too.
  - Aligned PC (pc[1:0]==0): capture PC into `mem_adr`, set `mem_req`=1, go to REQ.
  - Misaligned PC: issue no request, stay in IDLE, push entry {parcel=0, pc, misaligned=1, page_fault=0} at the next edge.
- REQ: `mem_req` and `mem_adr` are held stable until `mem_ack`.
  - On ack: push {mem_q, mem_adr, misaligned=0, page_fault=mem_err}, drop `mem_req`, go to IDLE.
  - Error entries carry parcel=mem_q unchanged.
- Pop: the head is consumed at the edge where valid & !if_stall.
- Output `if_parcel_valid`: all ones when FIFO non-empty, else zero.
- When the FIFO is empty, `if_parcel`, `if_parcel_pc` and both flags read 0.
- Flush (has priority over push and pop):
  - FIFO is emptied at the edge. Any push or pop in the same cycle is dropped.
  - Flush in REQ with `mem_ack`=0: go to DISCARD. `mem_req` stays high.
  - Flush in REQ with `mem_ack`=1: the response is dropped and the state goes to IDLE.
  - DISCARD: wait for `mem_ack`, drop the response, go to IDLE. A further flush in DISCARD has no extra effect.
  - A misaligned PC accepted in a flush cycle is still pushed next edge. The flush applies to the old contents only.
- FIFO: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- Overflow cannot occur: accept requires count<DEPTH and there is at most one outstanding request. The verification engineer asserts push → count<DEPTH || pop.
- Simultaneous push and pop: count is unchanged; when empty, the pushed entry becomes head next cycle.
- Reset (`rstn`=0 at edge): FSM → IDLE, FIFO empty, `mem_req`=0, `mem_adr`=0.
  - All outputs are 0, including `if_stall_nxt_pc`.
  - An in-flight request is abandoned. The memory side is required to be reset with the same `rstn`.

## Timing
- PC accepted at cycle N → `mem_req` high at N+1.
- Earliest `mem_ack` is N+1 (same-cycle ack is allowed) → `if_parcel_valid` at N+2.
- Misaligned PC accepted at N → entry visible at N+1.
- Back-to-back throughput with same-cycle ack: one parcel per 2 cycles (accept, request).
- `if_flush` at cycle F → `if_parcel_valid`=0 at F+1.
- `mem_adr` and `mem_req` are registered. Head outputs are direct FIFO reads (registered storage, muxed by read pointer).

## Test plan
- Reset, then PC 'h200 with zero-wait memory returning 'h00000013 → `mem_req`/`mem_adr`='h200 at N+1; `if_parcel`='h13, `if_parcel_pc`='h200, valid='b11 at N+2.
- Fill: `if_stall`=1, fetch 'h200,'h204,'h208,'h20C.
  - Required: count=4 and `if_stall_nxt_pc`=1 while 'h210 is presented.
  - Release `if_stall` → parcels pop in order and 'h210 is accepted once count<4.
- Flush during a 3-wait-state request for 'h300: FIFO empties at F+1 and state is DISCARD.
  - The 'h300 data is never presented.
  - The next accepted PC 'h400 appears as head.
- `mem_err`=1 on ack for 'h500 → head has pc 'h500, `if_parcel_page_fault`=1, valid='b11.
- PC 'h202 → no `mem_req`; at N+1 the head has pc 'h202, `if_parcel_misaligned`=1, parcel=0.
- `rstn`=0 mid-REQ with 2 entries buffered → all outputs 0 next cycle; the fetch sequence is normal after release.
